// File: rtl/mouse_pkt_pkg.sv
// mouse_pkt_pkg: shared FSM state, byte-count constants and byte-index type for mouse_pkt_tx.
package mouse_pkt_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, SETTLE, WAIT_DONE, GAP} state_t;
  localparam int NB = 2;
  localparam int PKT_LEN_BASE = 6;
  localparam int PKT_LEN_CS = 7;
  typedef logic [2:0] idx_t;
endpackage

// File: rtl/mouse_pkt_if.sv
// mouse_pkt_if: sample input, UART byte handshake and status signals of mouse_pkt_tx.
interface mouse_pkt_if #(parameter int COORD_W = 9, parameter int LVL_W = 3);
  logic enable;
  logic sample_valid;
  logic [COORD_W-1:0] sample_x;
  logic [COORD_W-1:0] sample_y;
  logic [2:0] sample_buttons;
  logic [7:0] tx_data;
  logic tx_wr;
  logic tx_busy;
  logic clear_ovf;
  logic busy;
  logic packet_sent;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0] overflow_cnt;
  modport master (output enable, sample_valid, sample_x, sample_y, sample_buttons, tx_busy, clear_ovf,
                  input tx_data, tx_wr, busy, packet_sent, fifo_level, overflow_cnt);
  modport slave (input enable, sample_valid, sample_x, sample_y, sample_buttons, tx_busy, clear_ovf,
                 output tx_data, tx_wr, busy, packet_sent, fifo_level, overflow_cnt);
endinterface

// File: rtl/mouse_pkt_fifo.sv
// mouse_pkt_fifo: power-of-2 sample FIFO with wrap-around pointers and exact level; caller guards push/pop.
module mouse_pkt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] lvl_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      lvl_q <= lvl_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign rdata_o = mem_q[rd_q];
  assign full_o = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
endmodule

// File: rtl/mouse_pkt_tx.sv
// mouse_pkt_tx: queues mouse samples and sends them as sync/X/Y/buttons byte packets to a UART.
// Define MOUSE_PKT_CHECKSUM_EN to append a mod-256 checksum of bytes 1..5 as a 7th byte.
module mouse_pkt_tx
  import mouse_pkt_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int GAP_CYCLES = 100
) (
  input logic clk,
  input logic rst_n,
  mouse_pkt_if.slave bus
);
  localparam int W = 2*COORD_W + 3;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
`ifdef MOUSE_PKT_CHECKSUM_EN
  localparam int PKT_LEN = PKT_LEN_CS;
`else
  localparam int PKT_LEN = PKT_LEN_BASE;
`endif
  state_t state_q, state_d;
  idx_t idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [W-1:0] pkt_q, pkt_d, rdata;
  logic [7:0] tx_data_q, tx_data_d, ovf_q, ovf_d;
  logic tx_wr_q, tx_wr_d, sent_q, sent_d;
  logic push, pop, drop, full, empty;
  logic [LVL_W-1:0] level;
  logic [NB*8-1:0] xs, ys;
  logic [7:0] pb [PKT_LEN];
  assign pop = state_q == LOAD;
  assign push = bus.sample_valid && bus.enable && (!full || pop);
  assign drop = bus.sample_valid && bus.enable && full && !pop;
  mouse_pkt_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .wdata_i({bus.sample_buttons, bus.sample_y, bus.sample_x}),
    .rdata_o(rdata), .full_o(full), .empty_o(empty), .level_o(level)
  );
  assign xs = 16'(signed'(pkt_q[COORD_W-1:0]));
  assign ys = 16'(signed'(pkt_q[2*COORD_W-1:COORD_W]));
  always_comb begin
    pb[0] = SYNC_BYTE;
    pb[1] = xs[7:0];
    pb[2] = xs[15:8];
    pb[3] = ys[7:0];
    pb[4] = ys[15:8];
    pb[5] = {5'b0, pkt_q[W-1:2*COORD_W]};
`ifdef MOUSE_PKT_CHECKSUM_EN
    pb[6] = pb[1] + pb[2] + pb[3] + pb[4] + pb[5];
`endif
  end
  // A drop coinciding with clear_ovf still counts, so the counter restarts at 1.
  assign ovf_d = bus.clear_ovf ? {7'b0, drop} : (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
  assign pkt_d = pop ? rdata : pkt_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    gap_d = gap_q;
    tx_data_d = tx_data_q;
    tx_wr_d = 1'b0;
    sent_d = 1'b0;
    case (state_q)
      IDLE: state_d = empty ? IDLE : LOAD;
      LOAD: begin
        idx_d = '0;
        state_d = SEND;
      end
      SEND: if (!bus.tx_busy) begin
        tx_data_d = pb[idx_q];
        tx_wr_d = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) begin
        state_d = (idx_q == idx_t'(PKT_LEN-1)) ? GAP : SEND;
        idx_d = (idx_q == idx_t'(PKT_LEN-1)) ? idx_q : idx_q + idx_t'(1);
        gap_d = GW'(GAP_CYCLES);
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        sent_d = gap_q == GW'(1);
        state_d = (gap_q == GW'(1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      gap_q <= '0;
      pkt_q <= '0;
      tx_data_q <= '0;
      tx_wr_q <= 1'b0;
      sent_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      pkt_q <= pkt_d;
      tx_data_q <= tx_data_d;
      tx_wr_q <= tx_wr_d;
      sent_q <= sent_d;
      ovf_q <= ovf_d;
    end
  assign bus.tx_data = tx_data_q;
  assign bus.tx_wr = tx_wr_q;
  assign bus.busy = state_q != IDLE;
  assign bus.packet_sent = sent_q;
  assign bus.fifo_level = level;
  assign bus.overflow_cnt = ovf_q;
endmodule
